sub_pipe: RTL

SUB_PIPE -- requirements
Module: sub_pipe

---
 rtl/sub_pipe_pkg.sv | 26 ++
 rtl/sub_half_stage.sv | 22 ++
 rtl/sub_pipe.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sub_pipe_pkg.sv
// Shared constants for the two-stage subtract pipeline: default width,
// flag bit positions and the encodings of the two per-beat mode bits.
package sub_pipe_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bit positions inside the 4-bit flags word {neg, zero, ovf, borrow}
    localparam int unsigned FLAG_BORROW = 0;
    localparam int unsigned FLAG_OVF    = 1;
    localparam int unsigned FLAG_ZERO   = 2;
    localparam int unsigned FLAG_NEG    = 3;
    localparam int unsigned FLAG_W      = 4;

    // Interpretation of the operands
    typedef enum logic {
        ARITH_UNSIGNED = 1'b0,
        ARITH_SIGNED   = 1'b1
    } arith_mode_e;

    // Behaviour when the result is out of range
    typedef enum logic {
        OVF_WRAP     = 1'b0,
        OVF_SATURATE = 1'b1
    } ovf_mode_e;

endpackage

// File: rtl/sub_half_stage.sv
// N-bit subtractor slice with borrow chaining; one instance per pipeline stage.
module sub_half_stage #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         bin_i,
    output logic [N-1:0] diff_o,
    output logic         bout_o
);

    logic [N:0] wide;

    // Extend by one bit: the extra MSB of the difference is the borrow-out
    always_comb begin
        wide = {1'b0, a_i} - {1'b0, b_i} - {{N{1'b0}}, bin_i};
    end

    assign diff_o = wide[N-1:0];
    assign bout_o = wide[N];

endmodule

// File: rtl/sub_pipe.sv
// Two-stage pipelined subtractor A - B with signed/unsigned and
// wrap/saturate modes carried per beat, valid/ready on both sides.
// Stage 1 subtracts the low HALF bits; stage 2 finishes the high bits,
// then derives flags and applies saturation.
module sub_pipe
    import sub_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    // Derived low-slice width; leave at its default
    parameter int unsigned HALF  = WIDTH / 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic              sgn,
    input  logic              sat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  RES,
    output logic [FLAG_W-1:0] flags
);

    localparam int unsigned HI = WIDTH - HALF;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage 1 registers
    logic              s1_valid_q,  s1_valid_d;
    logic [HALF-1:0]   s1_lo_q,     s1_lo_d;
    logic              s1_borrow_q, s1_borrow_d;
    logic [HI-1:0]     s1_ahi_q,    s1_ahi_d;
    logic [HI-1:0]     s1_bhi_q,    s1_bhi_d;
    arith_mode_e       s1_sgn_q,    s1_sgn_d;
    ovf_mode_e         s1_sat_q,    s1_sat_d;

    // Stage 2 registers (drive the outputs directly)
    logic              s2_valid_q,  s2_valid_d;
    logic [WIDTH-1:0]  res_q,       res_d;
    logic [FLAG_W-1:0] flags_q,     flags_d;

    logic              en;
    logic [HALF-1:0]   lo_diff;
    logic              lo_bout;
    logic [HI-1:0]     hi_diff;
    logic              hi_bout;
    logic [WIDTH-1:0]  raw;
    logic [WIDTH-1:0]  fin;
    logic              a_neg, b_neg, ovf;

    // Single advance enable: the whole pipe moves or the whole pipe holds
    assign en        = !s2_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = s2_valid_q;
    assign RES       = res_q;
    assign flags     = flags_q;

    sub_half_stage #(.N(HALF)) u_lo (
        .a_i    (A[HALF-1:0]),
        .b_i    (B[HALF-1:0]),
        .bin_i  (1'b0),
        .diff_o (lo_diff),
        .bout_o (lo_bout)
    );

    sub_half_stage #(.N(HI)) u_hi (
        .a_i    (s1_ahi_q),
        .b_i    (s1_bhi_q),
        .bin_i  (s1_borrow_q),
        .diff_o (hi_diff),
        .bout_o (hi_bout)
    );

    // Stage 1 next state: capture low-slice result, high operands and modes
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_lo_d     = s1_lo_q;
        s1_borrow_d = s1_borrow_q;
        s1_ahi_d    = s1_ahi_q;
        s1_bhi_d    = s1_bhi_q;
        s1_sgn_d    = s1_sgn_q;
        s1_sat_d    = s1_sat_q;
        if (en) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_lo_d     = lo_diff;
                s1_borrow_d = lo_bout;
                s1_ahi_d    = A[WIDTH-1:HALF];
                s1_bhi_d    = B[WIDTH-1:HALF];
                s1_sgn_d    = arith_mode_e'(sgn);
                s1_sat_d    = ovf_mode_e'(sat);
            end
        end
    end

    // Stage 2 datapath: full raw difference, overflow, saturation
    always_comb begin
        raw   = {hi_diff, s1_lo_q};
        a_neg = s1_ahi_q[HI-1];
        b_neg = s1_bhi_q[HI-1];
        ovf   = (a_neg ^ b_neg) & (raw[WIDTH-1] ^ a_neg);
        fin   = raw;
        if (s1_sat_q == OVF_SATURATE) begin
            if (s1_sgn_q == ARITH_UNSIGNED) begin
                if (hi_bout) fin = '0;
            end else if (ovf) begin
                fin = a_neg ? SMIN : SMAX;
            end
        end
    end

    // Stage 2 next state: result and flags follow the beat out of stage 1
    always_comb begin
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        flags_d    = flags_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d                = fin;
                flags_d              = '0;
                flags_d[FLAG_BORROW] = hi_bout;
                flags_d[FLAG_OVF]    = ovf;
                flags_d[FLAG_ZERO]   = (fin == '0);
                flags_d[FLAG_NEG]    = (s1_sgn_q == ARITH_SIGNED) & fin[WIDTH-1];
            end
        end
    end

    // Stage 1 register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_lo_q     <= '0;
            s1_borrow_q <= 1'b0;
            s1_ahi_q    <= '0;
            s1_bhi_q    <= '0;
            s1_sgn_q    <= ARITH_UNSIGNED;
            s1_sat_q    <= OVF_WRAP;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lo_q     <= s1_lo_d;
            s1_borrow_q <= s1_borrow_d;
            s1_ahi_q    <= s1_ahi_d;
            s1_bhi_q    <= s1_bhi_d;
            s1_sgn_q    <= s1_sgn_d;
            s1_sat_q    <= s1_sat_d;
        end
    end

    // Stage 2 register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            flags_q    <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            flags_q    <= flags_d;
        end
    end

endmodule
